// File: rtl/gate_mux_sched.sv
// gate_mux_sched: round-robin scheduler sharing one gate evaluation unit among four requesters
module gate_mux_sched #(
  parameter int WD_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] req_gate_type,
  input  logic [7:0]  req_no_of_inp,
  input  logic [15:0] req_ops,
  output logic [3:0]  done,
  output logic        rsp_out,
  output logic [2:0]  rsp_status,
  output logic        busy,
  output logic        gu_en,
  output logic        gu_op_ack_in_pulse,
  output logic        gu_final_inp_ack,
  output logic        gu_err_clr,
  output logic [3:0]  gu_gate_type,
  output logic [1:0]  gu_no_of_inp,
  output logic [3:0]  gu_ops,
  output logic        gu_rst_n,
  input  logic        gu_out,
  input  logic        gu_op_ack_out,
  input  logic        gu_time_lim_err,
  input  logic [1:0]  gu_inp_num_err
);
  typedef enum logic [2:0] {IDLE, LAUNCH, ACK, FINAL, WAIT, RECOVER, RESP} state_t;
  localparam int CW = $clog2(WD_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(WD_CYCLES - 1);
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [3:0] type_q, type_d, ops_q, ops_d, pick_type;
  logic [1:0] ninp_q, ninp_d;
  logic [2:0] status_q, status_d;
  logic out_q, out_d, rec_n_q, rec_n_d, legal;
  logic [CW-1:0] wd_q, wd_d;
  // walk downward so the requester closest to the pointer wins
  always_comb begin
    pick = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (req[ptr_q + 2'(k)]) pick = ptr_q + 2'(k);
  end
  assign pick_type = req_gate_type[{pick, 2'b00} +: 4];
  assign legal = pick_type >= 4'd2 && pick_type <= 4'd8;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    type_d = type_q;
    ninp_d = ninp_q;
    ops_d = ops_q;
    status_d = status_q;
    out_d = out_q;
    rec_n_d = 1'b1;
    wd_d = wd_q;
    case (state_q)
      IDLE: if (|req) begin
        gnt_d = pick;
        type_d = pick_type;
        ninp_d = req_no_of_inp[{pick, 1'b0} +: 2];
        ops_d = req_ops[{pick, 2'b00} +: 4];
        status_d = legal ? 3'd0 : 3'd5;
        out_d = 1'b0;
        state_d = legal ? LAUNCH : RESP;
      end
      LAUNCH: state_d = ACK;
      ACK: state_d = FINAL;
      FINAL: begin
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        state_d = RECOVER;
        if (gu_inp_num_err != 2'b00) status_d = gu_inp_num_err[1] ? 3'd1 : 3'd2;
        else if (gu_time_lim_err) status_d = 3'd3;
        else if (gu_op_ack_out) begin
          status_d = 3'd0;
          out_d = gu_out;
        end
        else if (wd_q == WD_LAST) status_d = 3'd4;
        else state_d = WAIT;
        // a clean result or a hung unit is cleared by a full unit reset
        rec_n_d = !(state_d == RECOVER && (status_d == 3'd0 || status_d == 3'd4));
      end
      RECOVER: state_d = RESP;
      RESP: begin
        ptr_d = gnt_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      type_q <= '0;
      ninp_q <= '0;
      ops_q <= '0;
      status_q <= '0;
      out_q <= 1'b0;
      rec_n_q <= 1'b1;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      type_q <= type_d;
      ninp_q <= ninp_d;
      ops_q <= ops_d;
      status_q <= status_d;
      out_q <= out_d;
      rec_n_q <= rec_n_d;
      wd_q <= wd_d;
    end
  assign gu_en = state_q == LAUNCH;
  assign gu_op_ack_in_pulse = state_q == ACK;
  assign gu_final_inp_ack = state_q == FINAL;
  assign gu_err_clr = state_q == RECOVER && status_q inside {3'd1, 3'd2, 3'd3};
  assign gu_rst_n = reset & rec_n_q;
  assign gu_gate_type = type_q;
  assign gu_no_of_inp = ninp_q;
  assign gu_ops = ops_q;
  assign done = (state_q == RESP) ? 4'b0001 << gnt_q : 4'b0000;
  assign rsp_out = state_q == RESP && out_q;
  assign rsp_status = (state_q == RESP) ? status_q : 3'd0;
  assign busy = state_q != IDLE || (|req && reset);
endmodule

// File: doc/gate_mux_sched.md
# gate_mux_sched

Round-robin scheduler that shares one `logic_gate_mux` evaluation unit among four requesters. The block does the following for each job:
- captures the requester's gate type, input count and operands;
- drives the unit's input handshake;
- waits for the unit's result or error;
- returns the unit to idle (reset pulse after a result, `err_clr` after an error);
- returns a one-cycle response to the granted requester.

It sits between the requester ports and the gate unit, and is the only master of the unit.

## Interface
- `WD_CYCLES`, default 24: watchdog limit, in cycles spent in WAIT. Must be at least 20.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester request level. Held until the matching `done` bit.
- `req_gate_type`  in  16  4 bits per requester; requester i uses bits [4i+3:4i].
- `req_no_of_inp`  in  8  2 bits per requester.
- `req_ops`  in  16  4 operands per requester; bit 0 is op1.
- `done`  out  4  one-cycle response strobe; one-hot or zero.
- `rsp_out`  out  1  result bit; valid while `done` is nonzero.
- `rsp_status`  out  3  status code; valid while `done` is nonzero.
- `busy`  out  1  high from grant through the `done` cycle.
- `gu_en`, `gu_op_ack_in_pulse`, `gu_final_inp_ack`, `gu_err_clr`  out  1 each  gate-unit control strobes.
- `gu_gate_type`  out  4  to the gate unit.
- `gu_no_of_inp`  out  2  to the gate unit.
- `gu_ops`  out  4  to the gate unit; bit 0 drives op1.
- `gu_rst_n`  out  1  gate-unit reset. Equals `reset` AND `rec_n`, where `rec_n` is an internal register.
- `gu_out`, `gu_op_ack_out`, `gu_time_lim_err`  in  1 each  from the gate unit.
- `gu_inp_num_err`  in  2  from the gate unit.

## Operation
- Status codes:
  - 000 OK
  - 001 too few inputs (`gu_inp_num_err`=10)
  - 010 too many inputs (`gu_inp_num_err`=01)
  - 011 unit time limit (`gu_time_lim_err`)
  - 100 watchdog expired
  - 101 illegal gate type
- Legal gate types are 2 through 8. Any other value is rejected without launching the unit.
- Arbitration:
  - Round-robin over `req`; the priority pointer resets to 0.
  - After a grant to requester i, requester i+1 (mod 4) has highest priority.
  - The granted payload is captured into registers at grant. `gu_gate_type`, `gu_no_of_inp` and `gu_ops` hold it stable until the next grant.
- State machine:
  - **IDLE**: if any `req` is high, grant. An illegal type goes to RESP with status 101; otherwise go to LAUNCH.
  - **LAUNCH**: `gu_en`=1 for one cycle, then go to ACK.
  - **ACK**: `gu_op_ack_in_pulse`=1 for one cycle, then go to FINAL.
  - **FINAL**: `gu_final_inp_ack`=1 for one cycle, then go to WAIT. The watchdog counter clears.
  - **WAIT**: checks in priority order:
    - `gu_inp_num_err`≠0 → status 001 or 010;
    - else `gu_time_lim_err` → status 011;
    - else `gu_op_ack_out` → capture `gu_out`, status 000;
    - else counter reaching `WD_CYCLES` → status 100.
    
    Any of these goes to RECOVER.
  - **RECOVER** (one cycle):
    - status 000 or 100: `rec_n`=0, resetting the unit;
    - status 001–011: `gu_err_clr`=1.
    
    Then go to RESP.
  - **RESP**: `done`[grant]=1, drive `rsp_out` and `rsp_status`, advance the priority pointer, go to IDLE.
- `rsp_out` is 0 for every non-OK status.
- Requests are sampled only in IDLE. Deasserting `req` mid-job does not abort the job; `done` is still issued.

## Timing
- Reset values: all outputs 0 except `gu_rst_n`, which follows `reset` (low during reset). `rec_n` resets to 1. State is IDLE and the pointer is 0.
- Reset asserted mid-job: the job is discarded, no `done` is issued, and the unit is reset via `gu_rst_n`.
- Cycle numbering: A is the IDLE cycle in which the request is first sampled. Then LAUNCH is A+1, ACK A+2, FINAL A+3, and WAIT is entered at A+4.
- OK path: `gu_op_ack_out` is seen at A+6, RECOVER is A+7 and `done` is at A+8. Latency is 8 cycles.
- Input-count error path: the error flag is seen at A+5, RECOVER (`err_clr`) is A+6 and `done` is at A+7.
- Illegal-type path: `done` is at A+1, and no `gu_*` strobe is issued.
- Watchdog path: `done` is at A+4+`WD_CYCLES`+1.
- Back-to-back jobs: the next grant can occur in the IDLE cycle right after RESP, so throughput is one job per 9 cycles on the OK path.
- Every strobe (`gu_en`, `gu_op_ack_in_pulse`, `gu_final_inp_ack`, `gu_err_clr`, `rec_n` low, `done`) is exactly one cycle wide.

## Test plan
- Requester 0: gate type 2 (AND), `no_of_inp`=11, ops=1111 → `done`=0001 at A+8, `rsp_out`=1, `rsp_status`=000; `gu_rst_n` low at A+7 only.
- Requester 2: gate type 4 (NOT), `no_of_inp`=01 → `gu_err_clr` at A+6, then `done`=0100 at A+7 with `rsp_status`=010 and `rsp_out`=0.
- Requester 1: gate type 7 (XOR), `no_of_inp`=00 → `rsp_status`=001. Then gate type 7, `no_of_inp`=10, ops=0111 → `rsp_out`=1, status 000.
- All four `req` high with legal jobs → `done` order 0001, 0010, 0100, 1000, spaced 9 cycles apart. Then re-request 0 and 3 together → 3 before 0 is not required; the pointer gives 0 first.
- Requester 3: gate type 12 → `done`=1000 at A+1, status 101, no `gu_en` pulse.
- Stalled unit model (never acks) → status 100 after `WD_CYCLES` cycles in WAIT, with a `gu_rst_n` pulse. Also assert `reset` at A+5 of a separate job → all outputs 0 and no `done` issued.
